// File: rtl/sio_l2b_rsp_collector.sv
// sio_l2b_rsp_collector
// Collects one L2 bank's read-response packets (one header beat followed by
// sixteen data beats), checks per-halfword even parity on every beat, and
// assembles a 64-byte line with its ctag and error flags. Completed lines are
// queued in a small circular buffer and presented on a registered
// valid/ready interface toward the SIO egress arbiter. Each freed buffer
// entry is returned to the bank as a one-cycle credit pulse.

module sio_l2b_rsp_collector #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             iol2clk,
  input  logic             rst,
  input  logic             l2b_sio_ctag_vld,
  input  logic [31:0]      l2b_sio_data,
  input  logic [1:0]       l2b_sio_parity,
  input  logic             l2b_sio_ue_err,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [15:0]      rsp_ctag,
  output logic [511:0]     rsp_data,
  output logic             rsp_perr,
  output logic             rsp_ue,
  output logic             sio_l2b_credit,
  output logic             ovf_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] perr_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       LAST_BEAT = 4'd15;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE,
    DATA
  } state_t;

  // Receive FSM state and data-beat index
  state_t     state_q;
  state_t     state_d;
  logic [3:0] beat_q;
  logic [3:0] beat_d;

  // Per-cycle beat classification from the FSM
  logic hdr_beat;
  logic data_wr;
  logic pkt_done;
  logic proto_hit;

  // Parity and error evaluation of the current beat
  logic par_bad_hi;
  logic par_bad_lo;
  logic beat_perr;

  // Staging area for the packet being assembled
  logic [31:0]  stg_word [16];
  logic [511:0] stg_line;
  logic [15:0]  stg_ctag;
  logic         stg_perr;
  logic         stg_ue;
  logic         done_pend;

  // Packet buffer storage and bookkeeping
  logic [15:0]      buf_ctag [DEPTH];
  logic [511:0]     buf_data [DEPTH];
  logic             buf_perr [DEPTH];
  logic             buf_ue   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_after_pop;
  logic             pop;
  logic             push;
  logic             drop;

  // Circular pointer advance with explicit wrap at DEPTH-1
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + PTR_ONE;
  endfunction

  // Receive FSM state register; reset abandons any partial packet
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic: a header restarts the packet from any state, beat 15 completes it
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    hdr_beat  = 1'b0;
    data_wr   = 1'b0;
    pkt_done  = 1'b0;
    proto_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (l2b_sio_ctag_vld) begin
          hdr_beat = 1'b1;
          state_d  = DATA;
          beat_d   = '0;
        end
      end
      DATA: begin
        if (l2b_sio_ctag_vld) begin
          proto_hit = 1'b1;
          hdr_beat  = 1'b1;
          beat_d    = '0;
        end else begin
          data_wr = 1'b1;
          if (beat_q == LAST_BEAT) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
            beat_d   = '0;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Even parity per halfword; a beat counts as one parity error regardless of how many halves mismatch
  always_comb begin
    par_bad_hi = (^l2b_sio_data[31:16]) != l2b_sio_parity[1];
    par_bad_lo = (^l2b_sio_data[15:0])  != l2b_sio_parity[0];
    beat_perr  = (hdr_beat || data_wr) && (par_bad_hi || par_bad_lo);
  end

  // Staging data words; every slot is rewritten by each packet so no reset is needed
  always_ff @(posedge iol2clk) begin
    if (data_wr) begin
      stg_word[beat_q] <= l2b_sio_data;
    end
  end

  // Flatten staging words so beat 0 lands in the most significant word
  always_comb begin
    stg_line = '0;
    for (int i = 0; i < 16; i++) begin
      stg_line[511 - 32*i -: 32] = stg_word[i];
    end
  end

  // Staging ctag and error flags; a header beat restarts them from its own parity/ue status
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      stg_ctag  <= '0;
      stg_perr  <= 1'b0;
      stg_ue    <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      done_pend <= pkt_done;
      if (hdr_beat) begin
        stg_ctag <= l2b_sio_data[15:0];
        stg_perr <= beat_perr;
        stg_ue   <= l2b_sio_ue_err;
      end else if (data_wr) begin
        stg_perr <= stg_perr | beat_perr;
        stg_ue   <= stg_ue | l2b_sio_ue_err;
      end
    end
  end

  // Push/pop decisions; a pop in the completion cycle makes room on a full buffer
  always_comb begin
    pop           = rsp_vld && rsp_rdy;
    push          = done_pend && ((occ_q != OCC_FULL) || pop);
    drop          = done_pend && !push;
    occ_after_pop = pop ? (occ_q - OCC_ONE) : occ_q;
    rd_next       = pop ? ptr_inc(rd_ptr) : rd_ptr;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Buffer entry storage, written at the tail on a successful push
  always_ff @(posedge iol2clk) begin
    if (push) begin
      buf_ctag[wr_ptr] <= stg_ctag;
      buf_data[wr_ptr] <= stg_line;
      buf_perr[wr_ptr] <= stg_perr;
      buf_ue[wr_ptr]   <= stg_ue;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_next;
      occ_q  <= occ_d;
    end
  end

  // Registered head view; an entry pushed this cycle becomes visible one cycle later
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_ctag <= '0;
      rsp_data <= '0;
      rsp_perr <= 1'b0;
      rsp_ue   <= 1'b0;
    end else begin
      rsp_vld <= (occ_after_pop != '0);
      if (occ_after_pop != '0) begin
        rsp_ctag <= buf_ctag[rd_next];
        rsp_data <= buf_data[rd_next];
        rsp_perr <= buf_perr[rd_next];
        rsp_ue   <= buf_ue[rd_next];
      end
    end
  end

  // Status outputs: credit and protocol pulses, sticky overflow, saturating parity count
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      sio_l2b_credit <= 1'b0;
      proto_err      <= 1'b0;
      ovf_err        <= 1'b0;
      perr_cnt       <= '0;
    end else begin
      sio_l2b_credit <= pop;
      proto_err      <= proto_hit;
      ovf_err        <= ovf_err | drop;
      if (beat_perr && (perr_cnt != CNT_MAX)) begin
        perr_cnt <= perr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_sio_l2b_rsp_collector.sv
// tb_sio_l2b_rsp_collector
// Directed bench for the L2 bank response collector. Expected packets are
// queued when their stimulus is driven and compared when the DUT hands them
// off on rsp_vld && rsp_rdy; credit and protocol pulses are checked every cycle.

module tb_sio_l2b_rsp_collector;

  logic         iol2clk = 1'b0;
  logic         rst = 1'b1;
  logic         l2b_sio_ctag_vld = 1'b0;
  logic [31:0]  l2b_sio_data = '0;
  logic [1:0]   l2b_sio_parity = '0;
  logic         l2b_sio_ue_err = 1'b0;
  logic         rsp_vld;
  logic         rsp_rdy = 1'b0;
  logic [15:0]  rsp_ctag;
  logic [511:0] rsp_data;
  logic         rsp_perr;
  logic         rsp_ue;
  logic         sio_l2b_credit;
  logic         ovf_err;
  logic         proto_err;
  logic [7:0]   perr_cnt;

  int   checks = 0;
  int   errors = 0;
  int   credit_seen = 0;
  logic exp_proto = 1'b0;

  typedef struct {
    logic [15:0]  ctag;
    logic [511:0] data;
    logic         perr;
    logic         ue;
  } exp_t;

  exp_t sb[$];

  sio_l2b_rsp_collector #(.DEPTH(2), .CNT_W(8)) dut (
    .iol2clk          (iol2clk),
    .rst              (rst),
    .l2b_sio_ctag_vld (l2b_sio_ctag_vld),
    .l2b_sio_data     (l2b_sio_data),
    .l2b_sio_parity   (l2b_sio_parity),
    .l2b_sio_ue_err   (l2b_sio_ue_err),
    .rsp_vld          (rsp_vld),
    .rsp_rdy          (rsp_rdy),
    .rsp_ctag         (rsp_ctag),
    .rsp_data         (rsp_data),
    .rsp_perr         (rsp_perr),
    .rsp_ue           (rsp_ue),
    .sio_l2b_credit   (sio_l2b_credit),
    .ovf_err          (ovf_err),
    .proto_err        (proto_err),
    .perr_cnt         (perr_cnt)
  );

  always #5 iol2clk = ~iol2clk;

  function automatic logic [1:0] goodPar(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any handoff at this edge, then check the per-cycle pulses
  task automatic tick();
    logic hs;
    exp_t e;
    hs = rsp_vld && rsp_rdy;
    if (hs) begin
      checkOutput("unexpected_rsp", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("rsp_ctag", rsp_ctag, e.ctag);
        checkOutput("rsp_data", rsp_data, e.data);
        checkOutput("rsp_perr", rsp_perr, e.perr);
        checkOutput("rsp_ue", rsp_ue, e.ue);
      end
    end
    @(posedge iol2clk);
    #1;
    if (sio_l2b_credit === 1'b1) credit_seen++;
    checkOutput("credit", sio_l2b_credit, hs);
    checkOutput("proto_err", proto_err, exp_proto);
    exp_proto = 1'b0;
  endtask

  task automatic applyStimulus(input logic vld, input logic [31:0] d, input logic [1:0] p, input logic ue);
    l2b_sio_ctag_vld = vld;
    l2b_sio_data     = d;
    l2b_sio_parity   = p;
    l2b_sio_ue_err   = ue;
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  // Header plus 16 data beats; bad-beat/ue indices of -1 mean none
  task automatic sendPacket(input logic [15:0] ctag, input logic [31:0] base, input int hi_bad,
                            input int lo_bad, input int ue_beat, input bit all_bad, input bit kept);
    exp_t        e;
    logic [31:0] w;
    logic [1:0]  p;
    e.ctag = ctag;
    e.data = '0;
    e.perr = all_bad || (hi_bad >= 0) || (lo_bad >= 0);
    e.ue   = (ue_beat >= 0);
    w = {16'h0000, ctag};
    p = goodPar(w);
    if (all_bad) p = ~p;
    applyStimulus(1'b1, w, p, 1'b0);
    for (int k = 0; k < 16; k++) begin
      w = base + 32'(k);
      p = goodPar(w);
      if (all_bad) p = ~p;
      if (k == hi_bad) p[1] = ~p[1];
      if (k == lo_bad) p[0] = ~p[0];
      e.data[511 - 32*k -: 32] = w;
      applyStimulus(1'b0, w, p, (k == ue_beat));
    end
    if (kept) sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || rsp_vld === 1'b1); i++) begin
      idle();
    end
    checkOutput("drain_sb_empty", sb.size(), 0);
    checkOutput("drain_vld_low", rsp_vld, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] w;
    int          c0;

    // Reset state
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    rst = 1'b0;
    checkOutput("rst_vld", rsp_vld, 0);
    checkOutput("rst_ovf", ovf_err, 0);
    checkOutput("rst_perr_cnt", perr_cnt, 0);
    checkOutput("rst_data", rsp_data, 0);

    // 1: single clean packet, latency to rsp_vld is header + 18
    $display("[TB] test 1: single packet");
    rsp_rdy = 1'b1;
    sendPacket(16'h00A5, 32'h1000_0000, -1, -1, -1, 1'b0, 1'b1);
    idle();
    checkOutput("vld_not_early", rsp_vld, 0);
    idle();
    checkOutput("vld_latency", rsp_vld, 1);
    checkOutput("t1_ctag", rsp_ctag, 16'h00A5);
    checkOutput("t1_first_word", rsp_data[511:480], 32'h1000_0000);
    checkOutput("t1_last_word", rsp_data[31:0], 32'h1000_000F);
    c0 = credit_seen;
    drain();
    checkOutput("t1_credit_count", credit_seen - c0, 1);

    // 2: parity errors on two data beats, then saturation
    $display("[TB] test 2: parity");
    sendPacket(16'h0011, 32'h2000_0000, 3, 9, -1, 1'b0, 1'b1);
    drain();
    checkOutput("t2_perr_cnt", perr_cnt, 2);
    for (int n = 0; n < 3; n++) sendPacket(16'(16'h0100 + n), 32'h2100_0000, -1, -1, -1, 1'b1, 1'b1);
    drain();
    checkOutput("t2_one_per_beat", perr_cnt, 53);
    for (int n = 0; n < 15; n++) sendPacket(16'(16'h0200 + n), 32'h2200_0000, -1, -1, -1, 1'b1, 1'b1);
    drain();
    checkOutput("t2_saturate", perr_cnt, 255);

    // 3: ue on the last beat only
    $display("[TB] test 3: ue");
    sendPacket(16'h0033, 32'h3000_0000, -1, -1, 15, 1'b0, 1'b1);
    drain();
    checkOutput("t3_perr_cnt_held", perr_cnt, 255);

    // 4a: push and pop in the same cycle on a full buffer
    $display("[TB] test 4a: full buffer push with pop");
    rsp_rdy = 1'b0;
    sendPacket(16'h0A01, 32'hA100_0000, -1, -1, -1, 1'b0, 1'b1);
    sendPacket(16'h0A02, 32'hA200_0000, -1, -1, -1, 1'b0, 1'b1);
    sendPacket(16'h0A03, 32'hA300_0000, -1, -1, -1, 1'b0, 1'b1);
    rsp_rdy = 1'b1;
    idle();
    checkOutput("t4a_no_ovf", ovf_err, 0);
    drain();

    // 4: backpressure overflow drops the third packet
    $display("[TB] test 4: overflow");
    rsp_rdy = 1'b0;
    sendPacket(16'h0B01, 32'hB100_0000, -1, -1, -1, 1'b0, 1'b1);
    sendPacket(16'h0B02, 32'hB200_0000, -1, -1, -1, 1'b0, 1'b1);
    sendPacket(16'h0B03, 32'hB300_0000, -1, -1, -1, 1'b0, 1'b0);
    checkOutput("t4_ovf_before", ovf_err, 0);
    idle();
    checkOutput("t4_ovf_set", ovf_err, 1);
    for (int i = 0; i < 5; i++) begin
      idle();
      checkOutput("t4_stall_vld", rsp_vld, 1);
      checkOutput("t4_stall_ctag", rsp_ctag, sb[0].ctag);
      checkOutput("t4_stall_data", rsp_data, sb[0].data);
    end
    c0 = credit_seen;
    rsp_rdy = 1'b1;
    drain();
    checkOutput("t4_credit_count", credit_seen - c0, 2);
    checkOutput("t4_ovf_sticky", ovf_err, 1);

    // 5: header arrives at data beat 7
    $display("[TB] test 5: mid-packet header");
    w = 32'h0000_0077;
    applyStimulus(1'b1, w, goodPar(w), 1'b0);
    for (int k = 0; k < 7; k++) begin
      w = 32'h7700_0000 + 32'(k);
      applyStimulus(1'b0, w, goodPar(w), 1'b0);
    end
    exp_proto = 1'b1;
    sendPacket(16'h0042, 32'h4200_0000, -1, -1, -1, 1'b0, 1'b1);
    drain();

    // 6: reset at data beat 10
    $display("[TB] test 6: reset mid-packet");
    w = 32'h0000_0066;
    applyStimulus(1'b1, w, goodPar(w), 1'b0);
    for (int k = 0; k < 10; k++) begin
      w = 32'h6600_0000 + 32'(k);
      applyStimulus(1'b0, w, goodPar(w), 1'b0);
    end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("t6_ovf_cleared", ovf_err, 0);
    checkOutput("t6_perr_cnt_cleared", perr_cnt, 0);
    for (int i = 0; i < 25; i++) begin
      idle();
      checkOutput("t6_no_vld", rsp_vld, 0);
    end
    sendPacket(16'h0067, 32'h6700_0000, -1, -1, -1, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sio_l2b_rsp_collector.md
Name: sio_l2b_rsp_collector

Overview:
Receive-side stage in SIO for one L2 bank's read-response interface, i.e. the consumer of l2bN_sio_ctag_vld/data/parity/ue_err. Captures each 17-beat packet (one header beat, then 16 data beats), checks per-halfword parity, and assembles a 64-byte line with its ctag and error flags. Completed packets go into a small packet buffer drained by a valid/ready interface toward the SIO egress arbiter. One instance is used per bank (eight total).

Parameters:
DEPTH, 2, packet-buffer entries; legal values 2 or 4.
CNT_W, 8, width of the saturating error counters.

Ports:
iol2clk  input  1  I/O-L2 clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
l2b_sio_ctag_vld  input  1  header-beat strobe.
l2b_sio_data  input  32  header (ctag in [15:0], [31:16] reserved) or data word.
l2b_sio_parity  input  2  even parity: [1] over data[31:16], [0] over data[15:0].
l2b_sio_ue_err  input  1  uncorrectable-error flag, sampled on any beat.
rsp_vld  output  1  buffer head valid.
rsp_rdy  input  1  consumer accepts head when rsp_vld&&rsp_rdy.
rsp_ctag  output  16  head ctag.
rsp_data  output  512  head line; beat 0 in [511:480], beat 15 in [31:0].
rsp_perr  output  1  head packet had at least one parity error (header or data).
rsp_ue  output  1  head packet had ue_err on any beat.
sio_l2b_credit  output  1  one-cycle pulse per entry freed by a pop.
ovf_err  output  1  sticky; packet dropped because the buffer was full.
proto_err  output  1  one-cycle pulse; ctag_vld seen mid-packet.
perr_cnt  output  CNT_W  saturating count of beats with a parity error.

Behaviour:
- Reset: all outputs 0, FSM IDLE, buffer empty, counters 0. Reset mid-packet discards the partial packet; no credit is emitted.
- FSM states: IDLE, DATA (beat counter 0..15).
  - IDLE: ctag_vld=1 latches ctag and starts the packet; go to DATA with beat count 0. ctag_vld=0 stays IDLE; data is ignored.
  - DATA: each cycle writes the word to the staging line slot [511-32*beat -: 32]. Beat 15 completes the packet; go to IDLE.
- Packets are contiguous: 17 consecutive cycles, no bubbles.
- Parity is checked every beat, header included. A mismatch in either half sets the staging perr flag and increments perr_cnt by 1 (at most 1 per beat). perr_cnt saturates at all-ones.
- ue_err on any beat sets the staging ue flag.
- ctag_vld=1 while in DATA:
  - Pulse proto_err and discard the partial packet.
  - Treat the beat as a new header: latch ctag, reset the beat count to 0, stay in DATA.
- Packet completion, buffer not full: push ctag, line, perr and ue in the cycle after beat 15. rsp_vld rises one cycle later; total latency is header cycle + 18 to rsp_vld.
- Packet completion, buffer full: drop the packet and set ovf_err. ovf_err clears only on rst.
- The full check is made at completion time. A pop in the same cycle as the push frees a slot, so a simultaneous push and pop on a full buffer succeeds.
- Buffer: circular, DEPTH entries, pointers wrap modulo DEPTH, with an occupancy counter of width clog2(DEPTH)+1.
- Output: rsp_* show the head entry and are registered. rsp_ctag/data/perr/ue hold stable while rsp_vld && !rsp_rdy. rsp_rdy with rsp_vld=0 has no effect.
- Pop: the occupancy decrements and sio_l2b_credit pulses the next cycle. A push and pop in the same cycle leave the occupancy unchanged.
- A back-to-back header on the cycle after beat 15 is legal and is not a protocol error.

Test Plan:
1. Single packet: header 0x0000_00A5, data beats 0x1000_0000+k, correct parity, rsp_rdy=1 → rsp_vld at header+18 with rsp_ctag=0x00A5, rsp_data[511:480]=0x1000_0000 and [31:0]=0x1000_000F, perr=ue=0; credit pulse the cycle after the pop.
2. Parity error: flip parity[1] on data beat 3 and parity[0] on beat 9 → rsp_perr=1, perr_cnt=2. Then 300 bad beats → perr_cnt saturates at 255.
3. UE: ue_err=1 on beat 15 only → rsp_ue=1, rsp_perr=0.
4. Backpressure, DEPTH=2: rsp_rdy=0 while 3 back-to-back packets arrive → first two buffered, third dropped, ovf_err=1 and stays 1. Raise rsp_rdy → two pops, two credit pulses, data unchanged while stalled.
5. Mid-packet header: second ctag_vld (ctag 0x0042) at data beat 7 → proto_err pulse, exactly one packet delivered with ctag 0x0042 and its own 16 beats.
6. Reset at data beat 10 → no rsp_vld and no credit. A packet sent after rst deasserts completes normally.
